// File: rtl/sram_rw_arbiter.sv
// Two-port round-robin arbiter in front of a single-port RW0 SRAM macro.
// Clears the array after reset, then serves one access per cycle.
//
// Ports:
//   clock, reset        : clock, async active-high reset
//   reqN_valid/ready    : port N request handshake (N = 0, 1)
//   reqN_write/addr/wdata : port N access (1 = write)
//   respN_valid/rdata   : port N read data, one cycle after the read grant
//   init_done           : array cleared, requests are being served
//   ram_en/wmode/addr/wdata/rdata : RW0 macro port
module sram_rw_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter bit INIT_EN = 1'b1,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              resp0_valid,
  output logic [DATA_W-1:0] resp0_rdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              resp1_valid,
  output logic [DATA_W-1:0] resp1_rdata,
  output logic              init_done,
  output logic              ram_en,
  output logic              ram_wmode,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_t;

  localparam state_t S_RST = INIT_EN ? S_INIT : S_RUN;
  localparam logic [ADDR_W-1:0] LAST = '1;

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic              last_grant;

  logic run;
  logic init_wr;
  logic gnt0;
  logic gnt1;

  assign run = (state == S_RUN);

  // Gated by reset so the macro sees en = 0 while reset is held.
  assign init_wr = (state == S_INIT) && !reset;

  // On contention the port that did not win last time is served.
  assign gnt0 = run && req0_valid &&
                (!req1_valid || last_grant);
  assign gnt1 = run && req1_valid &&
                (!req0_valid || !last_grant);

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  always_comb begin
    ram_en    = 1'b0;
    ram_wmode = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    unique case (1'b1)
      init_wr: begin
        ram_en    = 1'b1;
        ram_wmode = 1'b1;
        ram_addr  = cnt;
        ram_wdata = INIT_VALUE;
      end
      gnt0: begin
        ram_en    = 1'b1;
        ram_wmode = req0_write;
        ram_addr  = req0_addr;
        ram_wdata = req0_wdata;
      end
      gnt1: begin
        ram_en    = 1'b1;
        ram_wmode = req1_write;
        ram_addr  = req1_addr;
        ram_wdata = req1_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_RST;
      cnt         <= '0;
      last_grant  <= 1'b1;
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
      init_done   <= !INIT_EN;
    end else begin
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
      unique case (state)
        S_INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state     <= S_RUN;
            init_done <= 1'b1;
          end
        end
        S_RUN: begin
          if (gnt0 || gnt1) last_grant <= gnt1;
          resp0_valid <= gnt0 && !req0_write;
          resp1_valid <= gnt1 && !req1_write;
        end
        default: state <= S_RST;
      endcase
    end
  end

  assign resp0_rdata = resp0_valid ? ram_rdata : '0;
  assign resp1_rdata = resp1_valid ? ram_rdata : '0;

endmodule

// File: tb/tb_sram_rw_arbiter.sv
// Directed bench for sram_rw_arbiter: init sweep, vector table,
// mid-init reset and the INIT_EN = 0 variant.
module tb_sram_rw_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // DUT a: INIT_EN = 1
  logic        rst_a;
  logic        v0a, w0a, v1a, w1a;
  logic [11:0] a0a, a1a;
  logic [31:0] d0a, d1a;
  logic        rdy0a, rdy1a, r0va, r1va, done_a;
  logic [31:0] r0da, r1da;
  logic        en_a, wm_a;
  logic [11:0] addr_a;
  logic [31:0] wd_a, rd_a;
  logic [31:0] mem_a [0:4095];

  sram_rw_arbiter #(.INIT_EN(1'b1)) dut_a (
    .clock(clk), .reset(rst_a),
    .req0_valid(v0a), .req0_ready(rdy0a), .req0_write(w0a),
    .req0_addr(a0a), .req0_wdata(d0a),
    .resp0_valid(r0va), .resp0_rdata(r0da),
    .req1_valid(v1a), .req1_ready(rdy1a), .req1_write(w1a),
    .req1_addr(a1a), .req1_wdata(d1a),
    .resp1_valid(r1va), .resp1_rdata(r1da),
    .init_done(done_a),
    .ram_en(en_a), .ram_wmode(wm_a), .ram_addr(addr_a),
    .ram_wdata(wd_a), .ram_rdata(rd_a)
  );

  always @(posedge clk) begin
    if (en_a) begin
      if (wm_a) mem_a[addr_a] <= wd_a;
      else rd_a <= mem_a[addr_a];
    end
  end

  // DUT b: INIT_EN = 0
  logic        rst_b;
  logic        v0b;
  logic [11:0] a0b;
  logic        rdy0b, rdy1b, r0vb, r1vb, done_b;
  logic [31:0] r0db, r1db;
  logic        en_b, wm_b;
  logic [11:0] addr_b;
  logic [31:0] wd_b, rd_b;
  logic [31:0] mem_b [0:4095];

  sram_rw_arbiter #(.INIT_EN(1'b0)) dut_b (
    .clock(clk), .reset(rst_b),
    .req0_valid(v0b), .req0_ready(rdy0b), .req0_write(1'b0),
    .req0_addr(a0b), .req0_wdata(32'h0),
    .resp0_valid(r0vb), .resp0_rdata(r0db),
    .req1_valid(1'b0), .req1_ready(rdy1b), .req1_write(1'b0),
    .req1_addr(12'h0), .req1_wdata(32'h0),
    .resp1_valid(r1vb), .resp1_rdata(r1db),
    .init_done(done_b),
    .ram_en(en_b), .ram_wmode(wm_b), .ram_addr(addr_b),
    .ram_wdata(wd_b), .ram_rdata(rd_b)
  );

  always @(posedge clk) begin
    if (en_b) begin
      if (wm_b) mem_b[addr_b] <= wd_b;
      else rd_b <= mem_b[addr_b];
    end
  end

  typedef struct {
    logic        v0, w0;
    logic [11:0] a0;
    logic [31:0] d0;
    logic        v1, w1;
    logic [11:0] a1;
    logic [31:0] d1;
    logic        rdy0, rdy1, en, wm;
    logic [11:0] addr;
    logic [31:0] wd;
    logic        r0v;
    logic [31:0] r0d;
    logic        r1v;
    logic [31:0] r1d;
  } vec_t;

  vec_t vt [18];

  task automatic chk_reset_a(input string tag);
    chk({tag, " en"}, 32'(en_a), 32'd0);
    chk({tag, " wmode"}, 32'(wm_a), 32'd0);
    chk({tag, " addr"}, 32'(addr_a), 32'd0);
    chk({tag, " wdata"}, wd_a, 32'd0);
    chk({tag, " init_done"}, 32'(done_a), 32'd0);
    chk({tag, " resp0_valid"}, 32'(r0va), 32'd0);
    chk({tag, " resp1_valid"}, 32'(r1va), 32'd0);
    chk({tag, " ready0"}, 32'(rdy0a), 32'd0);
  endtask

  // Called right after reset release at a falling edge.
  task automatic run_init(input string tag);
    int errs;
    errs = 0;
    for (int i = 0; i < 4096; i++) begin
      v0a = 1'b1; w0a = 1'b1; a0a = 12'h7; d0a = 32'h5a5a5a5a;
      v1a = 1'b1; w1a = 1'b0; a1a = 12'h9;
      #1;
      if (en_a !== 1'b1 || wm_a !== 1'b1 ||
          addr_a !== 12'(i) || wd_a !== 32'h0 ||
          rdy0a !== 1'b0 || rdy1a !== 1'b0 ||
          done_a !== 1'b0) begin
        if (errs < 4)
          $display("FAIL %s cycle %0d en=%b wm=%b addr=%h wd=%h rdy=%b%b done=%b",
                   tag, i, en_a, wm_a, addr_a, wd_a, rdy0a, rdy1a, done_a);
        errs++;
      end
      @(negedge clk);
    end
    total++;
    if (errs != 0) bad++;
    v0a = 1'b0; v1a = 1'b0;
    #1;
    chk({tag, " init_done"}, 32'(done_a), 32'd1);
    chk({tag, " idle en"}, 32'(en_a), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem_a[i] = 32'hffffffff;
      mem_b[i] = 32'h0;
    end
    mem_b[0] = 32'ha5a50001;

    vt[0]  = '{1,1,12'h123,32'hdeadbeef, 0,0,12'h0,32'h0,
               1,0,1,1,12'h123,32'hdeadbeef, 0,32'h0, 0,32'h0};
    vt[1]  = '{1,0,12'h123,32'h0, 0,0,12'h0,32'h0,
               1,0,1,0,12'h123,32'h0, 0,32'h0, 0,32'h0};
    vt[2]  = '{1,1,12'h010,32'h11111111, 0,0,12'h0,32'h0,
               1,0,1,1,12'h010,32'h11111111, 1,32'hdeadbeef, 0,32'h0};
    vt[3]  = '{0,0,12'h0,32'h0, 1,1,12'h020,32'h22222222,
               0,1,1,1,12'h020,32'h22222222, 0,32'h0, 0,32'h0};
    vt[4]  = '{0,0,12'h0,32'h0, 0,0,12'h0,32'h0,
               0,0,0,0,12'h0,32'h0, 0,32'h0, 0,32'h0};
    vt[5]  = '{1,0,12'h010,32'h0, 1,0,12'h020,32'h0,
               1,0,1,0,12'h010,32'h0, 0,32'h0, 0,32'h0};
    vt[6]  = '{1,0,12'h010,32'h0, 1,0,12'h020,32'h0,
               0,1,1,0,12'h020,32'h0, 1,32'h11111111, 0,32'h0};
    vt[7]  = '{1,0,12'h010,32'h0, 1,0,12'h020,32'h0,
               1,0,1,0,12'h010,32'h0, 0,32'h0, 1,32'h22222222};
    vt[8]  = '{1,0,12'h010,32'h0, 1,0,12'h020,32'h0,
               0,1,1,0,12'h020,32'h0, 1,32'h11111111, 0,32'h0};
    vt[9]  = '{0,0,12'h0,32'h0, 0,0,12'h0,32'h0,
               0,0,0,0,12'h0,32'h0, 0,32'h0, 1,32'h22222222};
    vt[10] = '{0,0,12'h0,32'h0, 1,0,12'h020,32'h0,
               0,1,1,0,12'h020,32'h0, 0,32'h0, 0,32'h0};
    vt[11] = '{0,0,12'h0,32'h0, 1,0,12'h020,32'h0,
               0,1,1,0,12'h020,32'h0, 0,32'h0, 1,32'h22222222};
    vt[12] = '{0,0,12'h0,32'h0, 1,0,12'h020,32'h0,
               0,1,1,0,12'h020,32'h0, 0,32'h0, 1,32'h22222222};
    vt[13] = '{1,0,12'h010,32'h0, 1,0,12'h020,32'h0,
               1,0,1,0,12'h010,32'h0, 0,32'h0, 1,32'h22222222};
    vt[14] = '{0,0,12'h0,32'h0, 1,1,12'h123,32'hcafef00d,
               0,1,1,1,12'h123,32'hcafef00d, 1,32'h11111111, 0,32'h0};
    vt[15] = '{1,0,12'h123,32'h0, 0,0,12'h0,32'h0,
               1,0,1,0,12'h123,32'h0, 0,32'h0, 0,32'h0};
    vt[16] = '{0,0,12'h0,32'h0, 1,0,12'h555,32'h0,
               0,1,1,0,12'h555,32'h0, 1,32'hcafef00d, 0,32'h0};
    vt[17] = '{0,0,12'h0,32'h0, 0,0,12'h0,32'h0,
               0,0,0,0,12'h0,32'h0, 0,32'h0, 1,32'h0};

    rst_a = 1'b1; rst_b = 1'b1;
    v0a = 0; w0a = 0; a0a = 0; d0a = 0;
    v1a = 0; w1a = 0; a1a = 0; d1a = 0;
    v0b = 0; a0b = 0;
    #12;
    chk_reset_a("rst a");
    chk("rst b init_done", 32'(done_b), 32'd1);
    chk("rst b en", 32'(en_b), 32'd0);

    // INIT_EN = 0: served immediately after reset.
    @(negedge clk);
    rst_b = 1'b0;
    v0b = 1'b1; a0b = 12'h0;
    #1;
    chk("b init_done", 32'(done_b), 32'd1);
    chk("b ready0", 32'(rdy0b), 32'd1);
    chk("b en", 32'(en_b), 32'd1);
    chk("b wmode", 32'(wm_b), 32'd0);
    @(negedge clk);
    v0b = 1'b0;
    #1;
    chk("b resp0_valid", 32'(r0vb), 32'd1);
    chk("b resp0_rdata", r0db, 32'ha5a50001);
    chk("b resp1_valid", 32'(r1vb), 32'd0);
    @(negedge clk);
    #1;
    chk("b resp0 drop", 32'(r0vb), 32'd0);

    // INIT_EN = 1: full clear sweep.
    @(negedge clk);
    rst_a = 1'b0;
    run_init("init1");

    @(negedge clk);
    for (int i = 0; i < 18; i++) begin
      v0a = vt[i].v0; w0a = vt[i].w0; a0a = vt[i].a0; d0a = vt[i].d0;
      v1a = vt[i].v1; w1a = vt[i].w1; a1a = vt[i].a1; d1a = vt[i].d1;
      #1;
      chk($sformatf("v%0d ready0", i), 32'(rdy0a), 32'(vt[i].rdy0));
      chk($sformatf("v%0d ready1", i), 32'(rdy1a), 32'(vt[i].rdy1));
      chk($sformatf("v%0d ram_en", i), 32'(en_a), 32'(vt[i].en));
      chk($sformatf("v%0d wmode", i), 32'(wm_a), 32'(vt[i].wm));
      chk($sformatf("v%0d addr", i), 32'(addr_a), 32'(vt[i].addr));
      chk($sformatf("v%0d wdata", i), wd_a, vt[i].wd);
      chk($sformatf("v%0d resp0_valid", i), 32'(r0va), 32'(vt[i].r0v));
      chk($sformatf("v%0d resp0_rdata", i), r0da, vt[i].r0d);
      chk($sformatf("v%0d resp1_valid", i), 32'(r1va), 32'(vt[i].r1v));
      chk($sformatf("v%0d resp1_rdata", i), r1da, vt[i].r1d);
      @(negedge clk);
    end

    // Reset with a read response in flight drops it at once.
    v0a = 1'b1; w0a = 1'b0; a0a = 12'h123;
    @(posedge clk);
    #2;
    v0a = 1'b0;
    chk("pre-rst resp0_valid", 32'(r0va), 32'd1);
    rst_a = 1'b1;
    #1;
    chk_reset_a("run rst");

    // Reset at init counter 0x800 restarts the sweep.
    @(negedge clk);
    rst_a = 1'b0;
    for (int i = 0; i < 12'h800; i++) @(negedge clk);
    #1;
    chk("mid addr", 32'(addr_a), 32'h800);
    chk("mid en", 32'(en_a), 32'd1);
    rst_a = 1'b1;
    #1;
    chk_reset_a("mid rst");
    @(negedge clk);
    rst_a = 1'b0;
    run_init("init2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
